trisc_control: RTL and testbench
================================

# trisc_control

Instruction sequencer for the TRISC processor. It owns the 4-bit program counter and steps each instruction through a fixed fetch/decode/execute cycle. Each step drives one-cycle control strobes to the accumulator, ALU and data memory, and loads the PC on jumps. It sits between the program ROM (addressed by `PC`, returning `INSTR` combinationally) and the datapath.

## Interface
Parameters:
- `ADDR_W`, 4, PC and operand width; program space is 2^ADDR_W words.
- `OP_W`, 4, opcode width; the instruction word is OP_W+ADDR_W bits.

Ports (clock and reset first):
- `CLK` in 1: single clock; all state changes on the rising edge.
- `CLEAR` in 1: reset, synchronous, active-high.
- `RUN` in 1: level; 1 = execute continuously, 0 = stop at the next instruction boundary.
- `INSTR` in 8: ROM word at `PC`; [7:4] opcode, [3:0] operand/target.
- `ZFLAG` in 1: accumulator-zero flag from the datapath.
- `PC` out 4: program counter.
- `IR` out 8: instruction register.
- `ACC_LD` out 1: accumulator load strobe.
- `ALU_OP` out 2: 00 pass, 01 add, 10 sub, 11 unused.
- `MEM_WR` out 1: data-memory write strobe; address is `IR[3:0]`.
- `HALTED` out 1: high while in HALT.
- `STATE` out 3: current state encoding, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4. Encodings 5–7 are illegal and go to IDLE next cycle.
- IDLE: stay while `RUN`=0; go to FETCH when `RUN`=1.
- FETCH: `IR` <= `INSTR`; go to DECODE.
- DECODE: no strobes; go to EXECUTE.
- EXECUTE actions by opcode (`IR[7:4]`):
  - 0 NOP: no strobe.
  - 1 LDA: `ACC_LD`=1, `ALU_OP`=00.
  - 2 ADD: `ACC_LD`=1, `ALU_OP`=01.
  - 3 SUB: `ACC_LD`=1, `ALU_OP`=10.
  - 4 STA: `MEM_WR`=1.
  - 5 JMP: load PC with the target.
  - 6 JZ: load PC with the target if `ZFLAG`=1, otherwise increment.
  - 7 HLT: go to HALT.
  - 8–F: treated as NOP.
- PC update at the end of EXECUTE:
  - JMP, or JZ taken: PC <= `IR[3:0]`.
  - HLT: PC unchanged.
  - All others: PC <= PC+1, modulo 16 (F wraps to 0, no carry out).
- EXECUTE exit: go to FETCH if `RUN`=1, else IDLE. HLT always goes to HALT.
- HALT: absorbing. Only `CLEAR` leaves it; `RUN` is ignored.
- Strobes (`ACC_LD`, `ALU_OP`, `MEM_WR`) are decoded from state and `IR`, asserted only in EXECUTE. They are 0/00 in every other state.

## Timing
- Reset (`CLEAR`=1 at an edge): state=IDLE, PC=0, IR=0, `ACC_LD`=0, `ALU_OP`=00, `MEM_WR`=0, `HALTED`=0, `STATE`=0.
- `CLEAR` overrides everything, in any state and mid-instruction. A pending jump or strobe is discarded.
- Instruction latency: 3 cycles (FETCH, DECODE, EXECUTE) with `RUN` held high. Throughput is one instruction per 3 cycles, with no IDLE cycle between instructions.
- `RUN` is sampled only in IDLE and at the end of EXECUTE. Dropping it mid-instruction completes that instruction.
- `ZFLAG` is sampled in the EXECUTE cycle of JZ.
- `INSTR` is sampled at the end of FETCH. The ROM must settle within one cycle of a PC change.
- `HALTED` is asserted the cycle after the HLT EXECUTE and is registered with the state.

## Structure
- Shared package `trisc_pkg`: state enum, opcode constants (`OP_NOP`…`OP_HLT`), `ALU_OP` codes, instruction field widths.
- Sub-module `trisc_pc`: 4-bit PC register with synchronous active-high clear, load (target) and increment-with-wrap, load having priority. The controller instantiates it.
- The FSM and the strobe decode stay in `trisc_control`.

## Test plan
- Reset mid-EXECUTE of ADD: assert `CLEAR` → next cycle PC=0, IR=00, `STATE`=0, no `ACC_LD` pulse.
- Program `LDA 3`, `ADD 4`, `STA 5` with `RUN`=1:
  - `ACC_LD` pulses in cycles 3 and 6.
  - `ALU_OP` = 00 then 01.
  - `MEM_WR` pulses in cycle 9.
  - PC reads 0,0,0,1,1,1,2,2,2,3.
- Wrap: PC=F executing NOP → PC=0 after EXECUTE.
- JZ 9 at PC=2 → PC=9 with `ZFLAG`=1, PC=3 with `ZFLAG`=0.
- `RUN` dropped during DECODE → instruction completes, then IDLE with PC advanced by 1. `RUN` re-raised → FETCH on the next cycle.
- HLT at PC=6 → `HALTED`=1, PC stays 6 with `RUN`=1 for 20 cycles. `CLEAR` → IDLE, PC=0.

Source files
------------

// File: rtl/trisc_pkg.sv
// Shared types and constants for the TRISC instruction sequencer.
package trisc_pkg;

    localparam int unsigned INSTR_ADDR_W = 4;
    localparam int unsigned INSTR_OP_W   = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExecute = 3'd3,
        StHalt    = 3'd4
    } state_e;

    localparam logic [INSTR_OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [INSTR_OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [INSTR_OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [INSTR_OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [INSTR_OP_W-1:0] OP_STA = 4'h4;
    localparam logic [INSTR_OP_W-1:0] OP_JMP = 4'h5;
    localparam logic [INSTR_OP_W-1:0] OP_JZ  = 4'h6;
    localparam logic [INSTR_OP_W-1:0] OP_HLT = 4'h7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/trisc_pc.sv
// Program counter: synchronous clear, then load, then increment with wrap.
module trisc_pc #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLEAR,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            pc_q <= '0;
        end else if (load) begin
            pc_q <= target;
        end else if (inc) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/trisc_control.sv
// TRISC sequencer: fetch/decode/execute FSM driving accumulator, ALU and memory strobes.
module trisc_control
    import trisc_pkg::*;
#(
    parameter int unsigned ADDR_W = INSTR_ADDR_W,
    parameter int unsigned OP_W   = INSTR_OP_W
) (
    input  logic                   CLK,
    input  logic                   CLEAR,
    input  logic                   RUN,
    input  logic [OP_W+ADDR_W-1:0] INSTR,
    input  logic                   ZFLAG,
    output logic [ADDR_W-1:0]      PC,
    output logic [OP_W+ADDR_W-1:0] IR,
    output logic                   ACC_LD,
    output logic [1:0]             ALU_OP,
    output logic                   MEM_WR,
    output logic                   HALTED,
    output logic [2:0]             STATE
);

    localparam int unsigned IW = OP_W + ADDR_W;

    state_e          state_q;
    logic [IW-1:0]   ir_q;
    logic            acc_ld_q;
    logic [1:0]      alu_op_q;
    logic            mem_wr_q;
    logic            halted_q;
    logic [OP_W-1:0] opcode;
    logic            pc_load;
    logic            pc_inc;

    assign opcode = ir_q[IW-1:ADDR_W];

    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (state_q == StExecute) begin
            pc_load = (opcode == OP_JMP) || ((opcode == OP_JZ) && ZFLAG);
            pc_inc  = !pc_load && (opcode != OP_HLT);
        end
    end

    trisc_pc #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .CLK    (CLK),
        .CLEAR  (CLEAR),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (ir_q[ADDR_W-1:0]),
        .pc     (PC)
    );

    // Strobes are registered on the DECODE->EXECUTE edge so they are high exactly in EXECUTE.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state_q  <= StIdle;
            ir_q     <= '0;
            acc_ld_q <= 1'b0;
            alu_op_q <= ALU_PASS;
            mem_wr_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            acc_ld_q <= 1'b0;
            alu_op_q <= ALU_PASS;
            mem_wr_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (RUN) state_q <= StFetch;
                end
                StFetch: begin
                    ir_q    <= INSTR;
                    state_q <= StDecode;
                end
                StDecode: begin
                    state_q <= StExecute;
                    case (opcode)
                        OP_LDA: begin
                            acc_ld_q <= 1'b1;
                            alu_op_q <= ALU_PASS;
                        end
                        OP_ADD: begin
                            acc_ld_q <= 1'b1;
                            alu_op_q <= ALU_ADD;
                        end
                        OP_SUB: begin
                            acc_ld_q <= 1'b1;
                            alu_op_q <= ALU_SUB;
                        end
                        OP_STA:  mem_wr_q <= 1'b1;
                        default: ;
                    endcase
                end
                StExecute: begin
                    if (opcode == OP_HLT) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= RUN ? StFetch : StIdle;
                    end
                end
                StHalt: ;
                default: begin
                    state_q  <= StIdle;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign IR     = ir_q;
    assign ACC_LD = acc_ld_q;
    assign ALU_OP = alu_op_q;
    assign MEM_WR = mem_wr_q;
    assign HALTED = halted_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_trisc_control.sv
// Bench for trisc_control: cycle model of the instruction semantics plus directed programs.
module tb_trisc_control;

    logic       CLK = 1'b0;
    logic       CLEAR, RUN, ZFLAG;
    logic [7:0] INSTR;
    logic [3:0] PC;
    logic [7:0] IR;
    logic       ACC_LD, MEM_WR, HALTED;
    logic [1:0] ALU_OP;
    logic [2:0] STATE;

    logic [7:0] rom [16];
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: architectural PC/IR plus the phase of the current instruction.
    // Phase numbers are the debug STATE values: 0 idle, 1 fetch, 2 decode, 3 execute, 4 halt.
    int m_pc, m_ir, m_phase;

    always #5 CLK = ~CLK;

    always_comb INSTR = rom[PC];

    trisc_control dut (
        .CLK    (CLK),
        .CLEAR  (CLEAR),
        .RUN    (RUN),
        .INSTR  (INSTR),
        .ZFLAG  (ZFLAG),
        .PC     (PC),
        .IR     (IR),
        .ACC_LD (ACC_LD),
        .ALU_OP (ALU_OP),
        .MEM_WR (MEM_WR),
        .HALTED (HALTED),
        .STATE  (STATE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        int op;
        op = m_ir / 16;
        if (CLEAR) begin
            m_phase = 0;
            m_pc    = 0;
            m_ir    = 0;
        end else begin
            case (m_phase)
                0: if (RUN) m_phase = 1;
                1: begin
                    m_ir    = int'(rom[m_pc]);
                    m_phase = 2;
                end
                2: m_phase = 3;
                3: begin
                    if (op == 7) begin
                        m_phase = 4;
                    end else begin
                        if (op == 5 || (op == 6 && ZFLAG)) m_pc = m_ir % 16;
                        else m_pc = (m_pc + 1) % 16;
                        m_phase = RUN ? 1 : 0;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge CLK) begin
        int op;
        bit in_exec;
        if (chk_en) begin
            op      = m_ir / 16;
            in_exec = (m_phase == 3);
            check("model_pc", 32'(PC), 32'(m_pc));
            check("model_ir", 32'(IR), 32'(m_ir));
            check("model_state", 32'(STATE), 32'(m_phase));
            check("model_halted", 32'(HALTED), 32'(m_phase == 4));
            check("model_acc_ld", 32'(ACC_LD), 32'(in_exec && op >= 1 && op <= 3));
            check("model_alu_op", 32'(ALU_OP), (in_exec && op >= 1 && op <= 3) ? 32'(op - 1) : 0);
            check("model_mem_wr", 32'(MEM_WR), 32'(in_exec && op == 4));
        end
    end

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Hold CLEAR, load a program, then release with RUN high: returns in cycle 1 (FETCH).
    task automatic start(input logic [7:0] prog [16], input logic z);
        CLEAR = 1'b1;
        RUN   = 1'b0;
        ZFLAG = z;
        step();
        for (int i = 0; i < 16; i++) rom[i] = prog[i];
        step();
        CLEAR = 1'b0;
        RUN   = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0] prog [16];
        int exp_pc [10];
        CLEAR = 1'b1;
        RUN   = 1'b0;
        ZFLAG = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        step();
        step();
        chk_en = 1'b1;
        check("reset_pc", 32'(PC), 0);
        check("reset_ir", 32'(IR), 0);
        check("reset_state", 32'(STATE), 0);
        check("reset_halted", 32'(HALTED), 0);

        // LDA 3, ADD 4, STA 5
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h13; prog[1] = 8'h24; prog[2] = 8'h45;
        exp_pc = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
        start(prog, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("prog_pc_c%0d", c), 32'(PC), 32'(exp_pc[c-1]));
            check($sformatf("prog_acc_c%0d", c), 32'(ACC_LD), 32'(c == 3 || c == 6));
            check($sformatf("prog_memwr_c%0d", c), 32'(MEM_WR), 32'(c == 9));
            if (c == 3) check("prog_alu_lda", 32'(ALU_OP), 0);
            if (c == 6) check("prog_alu_add", 32'(ALU_OP), 1);
            step();
        end

        // CLEAR during EXECUTE of ADD discards the strobe and the PC increment
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h24;
        start(prog, 1'b0);
        step();
        step();
        check("midclr_acc_before", 32'(ACC_LD), 1);
        CLEAR = 1'b1;
        step();
        check("midclr_pc", 32'(PC), 0);
        check("midclr_ir", 32'(IR), 0);
        check("midclr_state", 32'(STATE), 0);
        check("midclr_acc", 32'(ACC_LD), 0);

        // JMP F, then NOP at F wraps to 0
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h5F;
        start(prog, 1'b0);
        for (int c = 1; c < 4; c++) step();
        check("wrap_pc_f", 32'(PC), 15);
        for (int c = 4; c < 7; c++) step();
        check("wrap_pc_0", 32'(PC), 0);

        // JMP 2, JZ 9: taken then not taken
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h52; prog[2] = 8'h69;
        for (int z = 1; z >= 0; z--) begin
            start(prog, 1'(z));
            for (int c = 1; c < 4; c++) step();
            check("jz_at_2", 32'(PC), 2);
            for (int c = 4; c < 7; c++) step();
            check($sformatf("jz_z%0d", z), 32'(PC), z ? 9 : 3);
        end

        // RUN dropped in DECODE: instruction finishes, then IDLE until RUN returns
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h11;
        start(prog, 1'b0);
        step();
        RUN = 1'b0;
        step();
        check("rundrop_exec", 32'(STATE), 3);
        check("rundrop_acc", 32'(ACC_LD), 1);
        step();
        check("rundrop_idle", 32'(STATE), 0);
        check("rundrop_pc", 32'(PC), 1);
        step();
        check("rundrop_stay", 32'(STATE), 0);
        RUN = 1'b1;
        step();
        check("rerun_fetch", 32'(STATE), 1);

        // JMP 6, HLT: absorbing until CLEAR
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h56; prog[6] = 8'h70;
        start(prog, 1'b0);
        for (int c = 1; c < 7; c++) step();
        check("hlt_halted", 32'(HALTED), 1);
        check("hlt_state", 32'(STATE), 4);
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("hlt_pc_%0d", c), 32'(PC), 6);
            check($sformatf("hlt_hold_%0d", c), 32'(HALTED), 1);
        end
        CLEAR = 1'b1;
        step();
        check("hlt_clr_state", 32'(STATE), 0);
        check("hlt_clr_pc", 32'(PC), 0);
        check("hlt_clr_halted", 32'(HALTED), 0);
        CLEAR = 1'b0;
        RUN   = 1'b0;
        step();
        check("post_clr_idle", 32'(STATE), 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
